multicycle_control: RTL and testbench

//  Main control FSM for the multi-cycle LEGv8 datapath. Sequences each instruction through

---
 rtl/legv8_pkg.sv | 49 ++++
 rtl/opcode_class.sv | 31 +++
 rtl/multicycle_control.sv | 161 ++++++++++++++++
 tb/tb_multicycle_control.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared encodings for the multi-cycle LEGv8 control path: opcodes, mux selects and FSM states.
package legv8_pkg;

  localparam int unsigned OPC_W            = 11;
  localparam int unsigned MEM_WAIT_MAX_DEF = 15;
  localparam int unsigned CNT_W_DEF        = 4;

  // Full 11-bit opcodes
  localparam logic [10:0] OPC_ADD  = 11'b10001011000;
  localparam logic [10:0] OPC_SUB  = 11'b11001011000;
  localparam logic [10:0] OPC_AND  = 11'b10001010000;
  localparam logic [10:0] OPC_ORR  = 11'b10101010000;
  localparam logic [10:0] OPC_LSL  = 11'b11010011011;
  localparam logic [10:0] OPC_LDUR = 11'b11111000010;
  localparam logic [10:0] OPC_STUR = 11'b11111000000;

  // Short-prefix opcodes, matched against the top bits of Opcode
  localparam logic [9:0]  OPC_ORRI = 10'b1011001000;
  localparam logic [7:0]  OPC_CBZ  = 8'b10110100;
  localparam logic [5:0]  OPC_B    = 6'b000101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    EXEC_R  = 4'd2,
    RWB     = 4'd3,
    ADDR    = 4'd4,
    MEMRD   = 4'd5,
    MEMWR   = 4'd6,
    LDWB    = 4'd7,
    BRANCH  = 4'd8,
    JUMP    = 4'd9,
    ILLEGAL = 4'd10
  } state_e;

endpackage

// File: rtl/opcode_class.sv
// Combinational opcode classifier: sorts IR[31:21] into the instruction groups the FSM dispatches on.
module opcode_class
  import legv8_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output logic             is_r,
  output logic             is_imm,
  output logic             is_ld,
  output logic             is_st,
  output logic             is_cbz,
  output logic             is_b,
  output logic             illegal
);

  logic is_lsl;
  logic is_orri;

  assign is_lsl  = (opcode == OPC_LSL);
  assign is_orri = (opcode[OPC_W-1 -: 10] == OPC_ORRI);

  // is_r covers everything executed in EXEC_R; is_imm picks the immediate B operand there
  assign is_r    = (opcode == OPC_ADD) | (opcode == OPC_SUB) | (opcode == OPC_AND) |
                   (opcode == OPC_ORR) | is_lsl | is_orri;
  assign is_imm  = is_lsl | is_orri;
  assign is_ld   = (opcode == OPC_LDUR);
  assign is_st   = (opcode == OPC_STUR);
  assign is_cbz  = (opcode[OPC_W-1 -: 8] == OPC_CBZ);
  assign is_b    = (opcode[OPC_W-1 -: 6] == OPC_B);
  assign illegal = ~(is_r | is_ld | is_st | is_cbz | is_b);

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle LEGv8 datapath: sequences fetch through writeback,
// supervises memory wait states with a timeout, and flags illegal opcodes.
module multicycle_control
  import legv8_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = MEM_WAIT_MAX_DEF,
  parameter int unsigned CNT_W        = CNT_W_DEF
) (
  input  logic             CLK,
  input  logic             Reset_n,
  input  logic [10:0]      Opcode,
  input  logic             Zero,
  input  logic             MemReady,
  output logic             PCEn,
  output logic             IRWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             MemtoReg,
  output logic             Reg2Loc,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUop,
  output logic [1:0]       PCSource,
  output logic             Illegal,
  output logic             MemFault,
  output logic [3:0]       State
);

  state_e           state, state_next;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_next;
  logic             reg2loc_q;

  logic is_r, is_imm, is_ld, is_st, is_cbz, is_b, opc_illegal;
  logic mem_state, timeout;
  logic pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write, illegal_st;

  opcode_class u_opcode_class (
    .opcode  (Opcode),
    .is_r    (is_r),
    .is_imm  (is_imm),
    .is_ld   (is_ld),
    .is_st   (is_st),
    .is_cbz  (is_cbz),
    .is_b    (is_b),
    .illegal (opc_illegal)
  );

  assign mem_state = (state == FETCH) || (state == MEMRD) || (state == MEMWR);
  assign timeout   = mem_state && !MemReady && (wait_cnt == CNT_W'(MEM_WAIT_MAX));

  always_ff @(posedge CLK or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= FETCH;
      wait_cnt  <= '0;
      reg2loc_q <= 1'b0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
      if (state == DECODE) reg2loc_q <= is_st | is_cbz;
    end
  end

  // Next state and wait counter
  always_comb begin
    state_next    = state;
    wait_cnt_next = wait_cnt;
    if (mem_state && !MemReady) wait_cnt_next = wait_cnt + CNT_W'(1);
    case (state)
      FETCH:   if (MemReady) state_next = DECODE;
      DECODE: begin
        if (is_r)                state_next = EXEC_R;
        else if (is_ld || is_st) state_next = ADDR;
        else if (is_cbz)         state_next = BRANCH;
        else if (is_b)           state_next = JUMP;
        else                     state_next = ILLEGAL;
      end
      EXEC_R:  state_next = RWB;
      ADDR:    state_next = is_st ? MEMWR : MEMRD;
      MEMRD:   if (MemReady) state_next = LDWB;
      MEMWR:   if (MemReady) state_next = FETCH;
      default: state_next = FETCH;
    endcase
    if (timeout) state_next = FETCH;
    // Counter restarts on every state change so each memory state gets a fresh budget
    if ((state_next != state) || timeout) wait_cnt_next = '0;
  end

  // Moore output decode; strobes are qualified below
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    illegal_st    = 1'b0;
    IorD          = 1'b0;
    MemtoReg      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = SRCB_REG;
    ALUop         = ALUOP_ADD;
    PCSource      = PCSRC_ALU;
    case (state)
      FETCH: begin
        mem_read = 1'b1;
        ALUSrcB  = SRCB_FOUR;
        ir_write = MemReady;
        pc_write = MemReady;
      end
      DECODE:  ALUSrcB = SRCB_IMM_SH;
      EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUop   = ALUOP_RTYPE;
        ALUSrcB = is_imm ? SRCB_IMM : SRCB_REG;
      end
      RWB:     reg_write = 1'b1;
      ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      MEMRD: begin
        mem_read = 1'b1;
        IorD     = 1'b1;
      end
      MEMWR: begin
        mem_write = 1'b1;
        IorD      = 1'b1;
      end
      LDWB: begin
        reg_write = 1'b1;
        MemtoReg  = 1'b1;
      end
      BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUop         = ALUOP_PASSB;
        pc_write_cond = 1'b1;
        PCSource      = PCSRC_ALUOUT;
      end
      JUMP: begin
        PCSource = PCSRC_JUMP;
        pc_write = 1'b1;
      end
      ILLEGAL: illegal_st = 1'b1;
      default: ;
    endcase
  end

  // Reset forces every strobe low immediately, independent of the clock
  assign PCEn     = Reset_n & (pc_write | (pc_write_cond & Zero));
  assign IRWrite  = Reset_n & ir_write;
  assign MemRead  = Reset_n & mem_read;
  assign MemWrite = Reset_n & mem_write;
  assign RegWrite = Reset_n & reg_write;
  assign Illegal  = Reset_n & illegal_st;
  assign MemFault = Reset_n & timeout;
  assign Reg2Loc  = (state == DECODE) ? (is_st | is_cbz) : reg2loc_q;
  assign State    = state;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomised scoreboard bench for multicycle_control: an instruction-level reference model
// expands each instruction into per-cycle expected outputs; a monitor compares every cycle.
`timescale 1ns/1ps
module tb_multicycle_control;
  import legv8_pkg::*;

  localparam int WAIT_LIMIT = 15;

  logic        CLK = 1'b0;
  logic        Reset_n = 1'b0;
  logic [10:0] Opcode = '0;
  logic        Zero = 1'b0;
  logic        MemReady = 1'b0;
  logic        PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUop, PCSource;
  logic        Illegal, MemFault;
  logic [3:0]  State;

  multicycle_control dut (
    .CLK(CLK), .Reset_n(Reset_n), .Opcode(Opcode), .Zero(Zero), .MemReady(MemReady),
    .PCEn(PCEn), .IRWrite(IRWrite), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg), .Reg2Loc(Reg2Loc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .PCSource(PCSource), .Illegal(Illegal),
    .MemFault(MemFault), .State(State)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] ctl;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_no = 0;
  bit          done = 1'b0;
  logic        r2l_m = 1'b0;
  logic        cur_imm = 1'b0;
  int          cur_abort = -1;
  bit          aborted = 1'b0;
  logic [16:0] act_ctl;

  assign act_ctl = {PCEn, IRWrite, IorD, MemRead, MemWrite, RegWrite, MemtoReg, Reg2Loc,
                    ALUSrcA, ALUSrcB, ALUop, PCSource, Illegal, MemFault};

  // Output table per state, straight from the control-signal description
  function automatic logic [16:0] model(input state_e st, input logic mr, input logic z,
                                        input logic flt, input logic imm, input logic r2l,
                                        input logic rst);
    logic pcen, irw, iord, mrd, mwr, rw, m2r, sa, ill, mf;
    logic [1:0] sb, op, pcs;
    {pcen, irw, iord, mrd, mwr, rw, m2r, sa, ill, mf} = '0;
    sb = 2'b00; op = 2'b00; pcs = 2'b00;
    case (st)
      FETCH:   begin mrd = 1; sb = 2'b01; if (flt) mf = 1; else if (mr) begin irw = 1; pcen = 1; end end
      DECODE:  sb = 2'b11;
      EXEC_R:  begin sa = 1; op = 2'b10; sb = imm ? 2'b10 : 2'b00; end
      RWB:     rw = 1;
      ADDR:    begin sa = 1; sb = 2'b10; end
      MEMRD:   begin mrd = 1; iord = 1; mf = flt; end
      MEMWR:   begin mwr = 1; iord = 1; mf = flt; end
      LDWB:    begin rw = 1; m2r = 1; end
      BRANCH:  begin sa = 1; op = 2'b01; pcs = 2'b01; pcen = z; end
      JUMP:    begin pcs = 2'b10; pcen = 1; end
      ILLEGAL: ill = 1;
      default: ;
    endcase
    if (rst) begin pcen = 0; irw = 0; mrd = 0; mwr = 0; rw = 0; end
    return {pcen, irw, iord, mrd, mwr, rw, m2r, r2l, sa, sb, op, pcs, ill, mf};
  endfunction

  // Drive one cycle of inputs, queue its expectation, advance to just after the next edge
  task automatic emit(input state_e st, input logic mr, input logic z, input logic flt,
                      input logic rst);
    exp_t e;
    Reset_n  = ~rst;
    MemReady = mr;
    Zero     = z;
    if (rst) r2l_m = 1'b0;
    e.st  = rst ? 4'(FETCH) : 4'(st);
    e.ctl = model(rst ? FETCH : st, mr, z, flt, cur_imm, r2l_m, rst);
    e.cyc = cyc_no;
    q.push_back(e);
    cyc_no++;
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    emit(FETCH, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    emit(FETCH, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
    aborted = 1'b1;
  endtask

  task automatic step(input state_e st, input logic z);
    if (aborted) return;
    if (int'(st) == cur_abort) begin do_reset(); return; end
    emit(st, 1'($urandom_range(0, 1)), z, 1'b0, 1'b0);
  endtask

  // Memory state: ready after w idle cycles, fault if still idle on the 16th cycle
  task automatic mem_phase(input state_e st, input int w, output bit ok);
    ok = 1'b0;
    if (aborted) return;
    if (int'(st) == cur_abort) begin do_reset(); return; end
    for (int c = 0; c <= WAIT_LIMIT; c++) begin
      if (c >= w) begin
        emit(st, 1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        ok = 1'b1;
        return;
      end
      if (c == WAIT_LIMIT) begin
        emit(st, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
        return;
      end
      emit(st, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end
  endtask

  task automatic run_instr(input logic [10:0] opc, input int wf, input int wm,
                           input logic zb, input int abort_st);
    bit r_i, imm_i, ld_i, st_i, cbz_i, b_i, ok;
    logic [10:0] o;
    o = opc;
    r_i   = (o == 11'b10001011000) || (o == 11'b11001011000) || (o == 11'b10001010000) ||
            (o == 11'b10101010000) || (o == 11'b11010011011) || (o[10:1] == 10'b1011001000);
    imm_i = (o == 11'b11010011011) || (o[10:1] == 10'b1011001000);
    ld_i  = (o == 11'b11111000010);
    st_i  = (o == 11'b11111000000);
    cbz_i = (o[10:3] == 8'b10110100);
    b_i   = (o[10:5] == 6'b000101);
    Opcode    = opc;
    cur_imm   = imm_i;
    cur_abort = abort_st;
    aborted   = 1'b0;
    mem_phase(FETCH, wf, ok);
    if (!ok) return;
    r2l_m = st_i | cbz_i;
    step(DECODE, 1'($urandom_range(0, 1)));
    if (r_i) begin
      step(EXEC_R, 1'($urandom_range(0, 1)));
      step(RWB, 1'($urandom_range(0, 1)));
    end else if (ld_i || st_i) begin
      step(ADDR, 1'($urandom_range(0, 1)));
      mem_phase(ld_i ? MEMRD : MEMWR, wm, ok);
      if (ld_i && ok) step(LDWB, 1'($urandom_range(0, 1)));
    end else if (cbz_i) begin
      step(BRANCH, zb);
    end else if (b_i) begin
      step(JUMP, 1'($urandom_range(0, 1)));
    end else begin
      step(ILLEGAL, 1'($urandom_range(0, 1)));
    end
  endtask

  function automatic int pick_wait();
    int r;
    int longw[4];
    longw = '{14, 15, 16, 18};
    r = $urandom_range(0, 9);
    if (r < 7) return $urandom_range(0, 3);
    return longw[$urandom_range(0, 3)];
  endfunction

  // Monitor: one expectation per cycle, sampled on the falling edge
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge CLK);
      if (done) break;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (State !== e.st) begin
          errors++;
          $display("FAIL state cyc %0d: got %0d expected %0d", e.cyc, State, e.st);
        end
        checks++;
        if (act_ctl !== e.ctl) begin
          errors++;
          $display("FAIL ctrl cyc %0d state %0d: got %05h expected %05h", e.cyc, e.st, act_ctl, e.ctl);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [10:0] opc;
    state_e      abort_set[7];
    abort_set = '{FETCH, DECODE, EXEC_R, RWB, ADDR, MEMRD, MEMWR};
    @(posedge CLK);
    #1;
    do_reset();
    // Directed cases
    run_instr(11'b10001011000, 0, 0, 1'b0, -1);             // ADD, no waits
    run_instr(11'b11111000010, 0, 3, 1'b0, -1);             // LDUR, 3 wait cycles in MEMRD
    run_instr(11'b10110100101, 1, 0, 1'b1, -1);             // CBZ taken
    run_instr(11'b10110100011, 0, 0, 1'b0, -1);             // CBZ not taken
    run_instr(11'b11111111111, 0, 0, 1'b0, -1);             // illegal
    run_instr(11'b11111000000, 0, 20, 1'b0, -1);            // STUR timeout
    run_instr(11'b11111000000, 0, 15, 1'b0, -1);            // STUR ready on the last count
    run_instr(11'b11111000010, 0, 16, 1'b0, -1);            // LDUR timeout
    run_instr(11'b10001011000, 16, 0, 1'b0, -1);            // fetch timeout
    run_instr(11'b10110010001, 15, 0, 1'b0, -1);            // ORRI, fetch ready on the last count
    run_instr(11'b11010011011, 2, 0, 1'b0, -1);             // LSL
    run_instr(11'b00010110101, 0, 0, 1'b0, -1);             // B
    run_instr(11'b11111000000, 0, 5, 1'b0, int'(MEMWR));    // reset during MEMWR
    run_instr(11'b10001011000, 0, 0, 1'b0, int'(RWB));      // reset during RWB
    run_instr(11'b11001011000, 0, 0, 1'b0, -1);             // SUB after reset
    // Randomised instruction mix
    for (int i = 0; i < 150; i++) begin
      case ($urandom_range(0, 10))
        0:  opc = 11'b10001011000;
        1:  opc = 11'b11001011000;
        2:  opc = 11'b10001010000;
        3:  opc = 11'b10101010000;
        4:  opc = 11'b11010011011;
        5:  opc = {10'b1011001000, 1'($urandom_range(0, 1))};
        6:  opc = 11'b11111000010;
        7:  opc = 11'b11111000000;
        8:  opc = {8'b10110100, 3'($urandom_range(0, 7))};
        9:  opc = {6'b000101, 5'($urandom_range(0, 31))};
        default: opc = 11'($urandom_range(0, 2047));
      endcase
      run_instr(opc, pick_wait(), pick_wait(), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 19) == 0) ? int'(abort_set[$urandom_range(0, 6)]) : -1);
    end
    emit(FETCH, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge CLK);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", q.size());
    end
    done = 1'b1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
